// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one fpu_add between NUM_REQ requesters, one op in flight,
// with a watchdog that turns a hung adder into a sticky fault.
module fpu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_din1,
  input  logic [32*NUM_REQ-1:0]  req_din2,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [31:0]            result,
  output logic                   err,
  output logic                   busy,
  output logic                   fault,
  output logic [31:0]            fpu_din1,
  output logic [31:0]            fpu_din2,
  output logic                   fpu_valid,
  input  logic [31:0]            fpu_result,
  input  logic                   fpu_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, RESPOND, HALT} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wdog;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-2 NUM_REQ never
  // visits an index past NUM_REQ-1.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      wdog      <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      fpu_din1  <= '0;
      fpu_din2  <= '0;
      fpu_valid <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      fpu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            fpu_din1      <= req_din1[32*int'(pick_idx) +: 32];
            fpu_din2      <= req_din2[32*int'(pick_idx) +: 32];
            idx           <= pick_idx;
            gnt[pick_idx] <= 1'b1;
            fpu_valid     <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (fpu_ready) begin
            result    <= fpu_result;
            done[idx] <= 1'b1;
            ptr       <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            state     <= RESPOND;
          end else if (wdog == WD_LAST) begin
            // ptr left alone: a timeout always ends in HALT, so fairness no longer matters
            result    <= QNAN;
            done[idx] <= 1'b1;
            err       <= 1'b1;
            state     <= RESPOND;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RESPOND: begin
          if (err) begin
            fault <= 1'b1;
            state <= HALT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
